flt2int_seq: RTL
================

Name: flt2int_seq

Overview:
Parametrised, synthesizable, multi-cycle float-to-signed-integer converter; successor to the behavioural half-precision converter.
- Generic exponent, mantissa and output widths.
- Run-time rounding mode: truncate toward zero or round-to-nearest-even.
- Saturating overflow and defined Inf/NaN handling.
- Serial one-bit-per-cycle shifter; sits between the program controller/data_mem glue and the test bench start/done handshake.

Parameters:
EXP_W, 5, exponent field width
MAN_W, 10, stored mantissa field width (hidden bit excluded)
INT_W, 16, two's-complement output width; must satisfy INT_W >= MAN_W+2

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  request; sampled only in IDLE
round_mode  in  1  0 = truncate toward zero, 1 = round-to-nearest-even; sampled with start
flt_in  in  1+EXP_W+MAN_W  {sign, exponent, mantissa}; sampled with start
busy  out  1  high from the cycle after accepted start until done cycle inclusive
done  out  1  one-cycle acknowledge pulse
int_out  out  INT_W  result; valid when done=1; held until next accepted start

Behaviour:
- Reset (synchronous, active-high): state=IDLE, done=0, busy=0, int_out=0. Reset asserted in any state aborts the operation; no done is produced.
- Definitions: BIAS = 2^(EXP_W-1)-1; e = exponent field; sig = {e!=0, mantissa}; k = e-BIAS when e!=0, 1-BIAS when e=0 (denormal).
- States: IDLE -> DECODE -> SHIFT (n cycles, n may be 0) -> ROUND -> IDLE.
- IDLE: on start=1 at edge t, capture flt_in and round_mode, go to DECODE. Start in any other state is ignored; no queueing.
- DECODE (edge t+1):
  - Classify the input. Special when e all-ones, or k > INT_W-1.
  - Otherwise load mag = sig (INT_W+1 bits), guard=0, sticky=0.
  - k >= MAN_W: left shift, n = k-MAN_W.
  - k < MAN_W: right shift, n = min(MAN_W-k, MAN_W+2).
  - Special inputs force n=0.
- SHIFT:
  - Each cycle shifts by one bit.
  - Right shift: guard <= mag[0]; sticky <= sticky | guard.
  - Decrement the counter; leave when it reaches 0.
- ROUND:
  - RNE: increment mag when guard & (sticky | mag[0]). Truncate: no increment.
  - Then saturate and sign-apply. Result is registered with done=1 on the following cycle.
- Latency: done high in the cycle after edge t+2+n. Examples: n=0 gives 3 cycles after start; 1.0 half (n=10) gives 13.
- Saturation, positive: mag > 2^(INT_W-1)-1 gives 2^(INT_W-1)-1.
- Saturation, negative: mag > 2^(INT_W-1) gives -2^(INT_W-1). Exactly 2^(INT_W-1) negative is exact, not flagged.
- Inf: saturate by sign. NaN (e all-ones, mantissa!=0): -2^(INT_W-1) regardless of sign. Large finite special: saturate by sign.
- Zero/denormal: result 0; sign ignored (no -0).
- Negative results: two's complement of mag, INT_W bits.

Optional Feature:
FLT2INT_STATUS_EN.
- Defined: adds output status[2:0] = {invalid(NaN), overflow(saturated non-NaN), inexact(guard|sticky nonzero or saturated)}, valid with done, held like int_out, reset 0.
- Undefined: port absent; datapath identical.

Decomposition:
- Package flt2int_pkg holds:
  - state enum {IDLE, DECODE, SHIFT, ROUND}
  - round mode enum {RM_TRUNC, RM_RNE}
  - function bias(EXP_W)
  - function sat_pos(INT_W)
  - function sat_neg(INT_W)
- One natural sub-module: flt_unpack (combinational). Takes flt_in; produces sign, sig, k, is_zero, is_inf, is_nan, and the shift direction/count.

Test Plan:
1. 0x3C00 (1.0), round_mode=0 -> int_out=0x0001, done exactly 13 cycles after start edge, busy high throughout.
2. 0x3E00 (1.5): RNE -> 0x0002, trunc -> 0x0001. 0x4100 (2.5): RNE -> 0x0002. 0x3A00 (0.75): RNE -> 0x0001. 0x3800 (0.5): RNE -> 0x0000.
3. 0xC500 (-5.0) -> 0xFFFB. 0x77FF (32752) -> 0x7FF0. 0x0001 (denormal) and 0x8000 (-0) -> 0x0000.
4. 0x7800 -> 0x7FFF. 0xF800 -> 0x8000, no overflow flag. 0x7C00 -> 0x7FFF. 0xFC00 -> 0x8000. 0x7E00 (NaN) -> 0x8000, invalid=1 under FLT2INT_STATUS_EN.
5. Second start pulsed during SHIFT -> ignored; exactly one done, for the first operand only.
6. Reset asserted mid-SHIFT -> next cycle state IDLE, busy=0, int_out=0, no done. A fresh start afterwards converts correctly.

Source files
------------

// File: rtl/flt2int_pkg.sv
// Shared types and helpers for the float-to-integer converter.
package flt2int_pkg;

    typedef enum logic [1:0] {IDLE, DECODE, SHIFT, ROUND} state_e;

    typedef enum logic {RM_TRUNC, RM_RNE} round_mode_e;

    // Exponent bias for an exponent field of the given width.
    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Largest positive two's-complement value of the given width.
    function automatic longint sat_pos(input int int_w);
        return (longint'(1) << (int_w - 1)) - 1;
    endfunction

    // Most negative two's-complement value of the given width.
    function automatic longint sat_neg(input int int_w);
        return -(longint'(1) << (int_w - 1));
    endfunction

endpackage

// File: rtl/flt_unpack.sv
// Combinational field decode: classifies the float and picks the shift direction and count.
module flt_unpack
    import flt2int_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int INT_W = 16,
    parameter int CNT_W = 5
) (
    input  logic [EXP_W+MAN_W:0]  flt_in,
    output logic                  sign,
    output logic [MAN_W:0]        sig,
    output logic signed [EXP_W+1:0] k,
    output logic                  is_zero,
    output logic                  is_inf,
    output logic                  is_nan,
    output logic                  shift_left,
    output logic [CNT_W-1:0]      shift_cnt
);

    localparam int BIAS = bias(EXP_W);
    localparam int K_W  = EXP_W + 2;

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_max;
    int               k_i;
    int               n_i;

    assign sign    = flt_in[EXP_W+MAN_W];
    assign exp_f   = flt_in[EXP_W+MAN_W-1:MAN_W];
    assign man_f   = flt_in[MAN_W-1:0];
    assign exp_max = &exp_f;
    assign sig     = {exp_f != '0, man_f};
    assign is_zero = (exp_f == '0) && (man_f == '0);
    assign is_inf  = exp_max && (man_f == '0);
    assign is_nan  = exp_max && (man_f != '0);

    // Unbiased exponent and shift plan; specials (Inf/NaN/too large) need no shifting.
    always_comb begin
        k_i        = (exp_f != '0) ? int'({1'b0, exp_f}) - BIAS : 1 - BIAS;
        n_i        = 0;
        shift_left = 1'b0;
        if (!exp_max && (k_i <= INT_W - 1)) begin
            if (k_i >= MAN_W) begin
                shift_left = 1'b1;
                n_i        = k_i - MAN_W;
            end else begin
                // Beyond MAN_W+2 steps every bit is already in sticky.
                n_i = (MAN_W - k_i < MAN_W + 2) ? MAN_W - k_i : MAN_W + 2;
            end
        end
    end

    assign k         = K_W'(k_i);
    assign shift_cnt = CNT_W'(n_i);

endmodule

// File: rtl/flt2int_seq.sv
// Multi-cycle float to signed integer converter with a one-bit-per-cycle shifter.
// Optional status output enabled by defining FLT2INT_STATUS_EN.
module flt2int_seq
    import flt2int_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int INT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 round_mode,
    input  logic [EXP_W+MAN_W:0] flt_in,
    output logic                 busy,
    output logic                 done,
    output logic [INT_W-1:0]     int_out
`ifdef FLT2INT_STATUS_EN
    ,
    output logic [2:0]           status
`endif
);

    localparam int FLT_W = 1 + EXP_W + MAN_W;
    localparam int MAG_W = INT_W + 1;
    localparam int CNT_W = $clog2(INT_W + 2);

    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(sat_pos(INT_W));
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(-sat_neg(INT_W));
    localparam logic [INT_W-1:0] POS_VAL = INT_W'(sat_pos(INT_W));
    localparam logic [INT_W-1:0] NEG_VAL = INT_W'(sat_neg(INT_W));

    state_e            state_q;
    logic [FLT_W-1:0]  flt_q;
    round_mode_e       rm_q;
    logic              sign_q, nan_q, ovf_q, zero_q, left_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [MAG_W-1:0]  mag_q;
    logic              guard_q, sticky_q;

    logic                   u_sign, u_zero, u_inf, u_nan, u_left;
    logic [MAN_W:0]         u_sig;
    logic signed [EXP_W+1:0] u_k;
    logic [CNT_W-1:0]       u_cnt;
    logic                   big_in;

    logic                   inc;
    logic [MAG_W-1:0]       mag_rnd;
    logic                   pos_ovf, neg_ovf;
    logic [INT_W-1:0]       res;

    flt_unpack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .INT_W (INT_W),
        .CNT_W (CNT_W)
    ) u_unpack (
        .flt_in     (flt_q),
        .sign       (u_sign),
        .sig        (u_sig),
        .k          (u_k),
        .is_zero    (u_zero),
        .is_inf     (u_inf),
        .is_nan     (u_nan),
        .shift_left (u_left),
        .shift_cnt  (u_cnt)
    );

    assign big_in = int'(u_k) > INT_W - 1;

    // Rounding increment, overflow detection and sign application for the ROUND state.
    always_comb begin
        inc     = (rm_q == RM_RNE) && guard_q && (sticky_q || mag_q[0]);
        mag_rnd = mag_q + MAG_W'(inc);
        pos_ovf = !sign_q && (mag_rnd > POS_LIM);
        neg_ovf = sign_q && (mag_rnd > NEG_LIM);
        res     = '0;
        if (nan_q) begin
            res = NEG_VAL;
        end else if (ovf_q) begin
            res = sign_q ? NEG_VAL : POS_VAL;
        end else if (pos_ovf) begin
            res = POS_VAL;
        end else if (neg_ovf) begin
            res = NEG_VAL;
        end else if (zero_q) begin
            res = '0;  // no negative zero
        end else if (sign_q) begin
            res = INT_W'(0) - mag_rnd[INT_W-1:0];
        end else begin
            res = mag_rnd[INT_W-1:0];
        end
    end

    // Control FSM, serial shifter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            done     <= 1'b0;
            busy     <= 1'b0;
            int_out  <= '0;
            flt_q    <= '0;
            rm_q     <= RM_TRUNC;
            sign_q   <= 1'b0;
            nan_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            left_q   <= 1'b0;
            cnt_q    <= '0;
            mag_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`ifdef FLT2INT_STATUS_EN
            status   <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        flt_q   <= flt_in;
                        rm_q    <= round_mode_e'(round_mode);
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    sign_q   <= u_sign;
                    nan_q    <= u_nan;
                    ovf_q    <= u_inf | big_in;
                    zero_q   <= u_zero;
                    left_q   <= u_left;
                    cnt_q    <= u_cnt;
                    mag_q    <= {{(MAG_W - MAN_W - 1){1'b0}}, u_sig};
                    guard_q  <= 1'b0;
                    sticky_q <= 1'b0;
                    state_q  <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        state_q <= ROUND;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (left_q) begin
                            mag_q <= mag_q << 1;
                        end else begin
                            mag_q    <= mag_q >> 1;
                            guard_q  <= mag_q[0];
                            sticky_q <= sticky_q | guard_q;
                        end
                    end
                end
                ROUND: begin
                    int_out <= res;
                    done    <= 1'b1;
                    state_q <= IDLE;
`ifdef FLT2INT_STATUS_EN
                    status  <= {nan_q,
                                !nan_q & (ovf_q | pos_ovf | neg_ovf),
                                guard_q | sticky_q | nan_q | ovf_q | pos_ovf | neg_ovf};
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
